fft64_tw_sequencer: RTL
=======================

# fft64_tw_sequencer

Sequencer for the 64-point radix-2² SDF FFT pipeline. It tracks each input sample's position as the sample moves through the pipeline. From that position it drives the twiddle-table address for the two complex-multiplier stages (stage 1: 64-point, stage 2: 16-point) and flags the multiplications that can be bypassed. It also frames the FFT output with valid and last strobes. It sits between the sample source and the `Twiddle64` instances, which are used with output register enabled (one-cycle lookup latency).

## Interface
Parameters:
- `S1_LAT`, 50: cycles from `di_en` to the stage-1 multiplier data input.
- `S2_LAT`, 63: cycles from `di_en` to the stage-2 multiplier data input.
- `OUT_LAT`, 70: cycles from `di_en` to the FFT output.
- Constraint: 2 ≤ `S1_LAT` < `S2_LAT` ≤ `OUT_LAT` ≤ 127. Violating it is a synthesis-time error.

Ports:
- `clock` in 1: master clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous restart of frame alignment.
- `di_en` in 1: input sample valid, one sample per high cycle; gaps allowed.
- `s1_tw_addr` out 6: twiddle address for stage 1, to `Twiddle64.addr`.
- `s1_tw_byp` out 1: stage-1 multiply bypass (address is 0).
- `s2_tw_addr` out 6: twiddle address for stage 2.
- `s2_tw_byp` out 1: stage-2 multiply bypass.
- `do_en` out 1: FFT output sample valid.
- `do_idx` out 6: output sample index within the frame.
- `do_last` out 1: high with the 64th output sample of a frame.
- `busy` out 1: at least one sample is in flight.

## Operation
**Valid delay line.** A shift register of `OUT_LAT` bits, clocked every cycle, with `di_en` shifted in at the head.
- Tap e1 is `di_en` delayed `S1_LAT-1` cycles.
- Tap e2 is `di_en` delayed `S2_LAT-1` cycles.
- Tap eo is `di_en` delayed `OUT_LAT` cycles.

**Per-tap counters.** Each tap has its own counter: k1 (6 bit), k2 (4 bit), ko (6 bit).
- A counter increments only on a cycle where its tap is high.
- Wrap-around: 63→0 for k1 and ko, 15→0 for k2.
- Sample j of a frame therefore sees k1 = j, k2 = j mod 16, ko = j. Input gaps do not disturb this alignment.

**Twiddle index.** Define m(q) = bit-reverse of the 2-bit quadrant q: 0→0, 1→2, 2→1, 3→3.

**Stage 1 (on e1).** Register s1_tw_addr = k1[3:0] × m(k1[5:4]). The maximum value is 45, so no overflow is possible. Register s1_tw_byp = (address == 0).

**Stage 2 (on e2).** Register s2_tw_addr = 4 × k2[1:0] × m(k2[3:2]). The maximum value is 36. Register s2_tw_byp = (address == 0).

**Address hold.** When a tap is low, its address and bypass registers hold their previous values.

**Output framing.**
- `do_en` is registered from eo.
- `do_idx` = ko for that sample.
- `do_last` = eo & (ko == 63).

**busy.** Combinational OR of all delay-line bits.

**clear.**
- Zeroes the delay line, all counters and all outputs at the next edge.
- Samples already in flight are discarded.
- When `clear` and `di_en` are high in the same cycle, `clear` wins and that sample is dropped.

**Reset.**
- Asserting `reset_n` (low) forces the same zero state asynchronously, including mid-frame.
- After release, the first `di_en` is sample 0 of a new frame.

## Timing
- For `di_en` high at edge t (sample j), `s1_tw_addr` and `s1_tw_byp` for j are valid from edge t+`S1_LAT`-1 until the next e1 event.
  - Twiddle64's output register then presents the factor at edge t+`S1_LAT`, aligned with the data.
- Stage 2 follows the same rule with `S2_LAT`.
- `do_en`, `do_idx` and `do_last` are high for exactly one cycle after edge t+`OUT_LAT`.
- Throughput: one sample per cycle sustained, with no stall.
- Reset values: every output is 0; `s1_tw_byp` and `s2_tw_byp` are 0 (not 1).

## Test plan
- **Reset, then a 64-sample burst with `di_en` held high.**
  - Stage-1 addresses: j=5 → 0 with bypass=1; j=21 → 10; j=41 → 9; j=63 → 45.
  - Each address appears `S1_LAT`-1 cycles after its `di_en`.
- **Same burst, stage 2.**
  - j=7 → 24; j=15 → 36; j=16 → 0 with bypass=1.
  - Each address appears at `S2_LAT`-1 cycles.
- **Gapped input (`di_en` every third cycle) for 2 frames.**
  - Address sequences match the dense case sample-for-sample.
  - `do_last` pulses exactly twice, each with `do_idx`=63.
- **Frame wrap: 130 contiguous samples.**
  - The 65th sample yields k1=0 and `s1_tw_addr`=0.
  - `do_idx` wraps 63→0 with no idle cycle.
- **`clear` asserted with `di_en` at sample 30.**
  - `busy` drops the next cycle; no `do_en` follows.
  - The next `di_en` produces `do_idx`=0 `OUT_LAT` cycles later.
- **`reset_n` pulsed low mid-frame (sample 40, asynchronous to the clock).**
  - All outputs go to 0 immediately.
  - After release, the sequence restarts at j=0.

Source files
------------

// File: rtl/fft64_tw_sequencer.sv
// Twiddle/framing sequencer for the 64-point radix-2^2 SDF FFT: follows each sample
// down a valid delay line and derives twiddle addresses, bypass flags and output strobes.
module fft64_tw_sequencer #(
    parameter int S1_LAT  = 50,
    parameter int S2_LAT  = 63,
    parameter int OUT_LAT = 70
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       di_en,
    output logic [5:0] s1_tw_addr,
    output logic       s1_tw_byp,
    output logic [5:0] s2_tw_addr,
    output logic       s2_tw_byp,
    output logic       do_en,
    output logic [5:0] do_idx,
    output logic       do_last,
    output logic       busy
);

    generate
        if (!(2 <= S1_LAT && S1_LAT < S2_LAT && S2_LAT <= OUT_LAT && OUT_LAT <= 127)) begin : g_bad_latency
            $error("fft64_tw_sequencer: latency parameters must satisfy 2 <= S1_LAT < S2_LAT <= OUT_LAT <= 127");
        end
    endgenerate

    // Bit-reversed quadrant: maps the radix-2^2 quadrant to its twiddle multiplier.
    function automatic logic [1:0] quad_rev(input logic [1:0] q);
        return {q[0], q[1]};
    endfunction

    logic [OUT_LAT-1:0] dl_q, dl_d;
    logic [5:0]         k1_q, k1_d;
    logic [3:0]         k2_q, k2_d;
    logic [5:0]         ko_q, ko_d;
    logic [5:0]         s1_addr_q, s1_addr_d;
    logic               s1_byp_q, s1_byp_d;
    logic [5:0]         s2_addr_q, s2_addr_d;
    logic               s2_byp_q, s2_byp_d;
    logic               do_en_q, do_en_d;
    logic [5:0]         do_idx_q, do_idx_d;
    logic               do_last_q, do_last_d;

    logic       e1, e2, eo;
    logic [5:0] s1_addr_calc, s2_addr_calc;

    // dl_q[d-1] carries di_en delayed by d cycles.
    assign e1 = dl_q[S1_LAT-2];
    assign e2 = dl_q[S2_LAT-2];
    assign eo = dl_q[OUT_LAT-1];

    assign s1_addr_calc = 6'(k1_q[3:0]) * 6'(quad_rev(k1_q[5:4]));
    assign s2_addr_calc = 6'({k2_q[1:0], 2'b00}) * 6'(quad_rev(k2_q[3:2]));

    always_comb begin
        dl_d      = {dl_q[OUT_LAT-2:0], di_en};
        k1_d      = k1_q;
        k2_d      = k2_q;
        ko_d      = ko_q;
        s1_addr_d = s1_addr_q;
        s1_byp_d  = s1_byp_q;
        s2_addr_d = s2_addr_q;
        s2_byp_d  = s2_byp_q;
        do_en_d   = eo;
        do_idx_d  = do_idx_q;
        do_last_d = eo && (ko_q == 6'd63);

        if (e1) begin
            k1_d      = k1_q + 6'd1;
            s1_addr_d = s1_addr_calc;
            s1_byp_d  = (s1_addr_calc == 6'd0);
        end
        if (e2) begin
            k2_d      = k2_q + 4'd1;
            s2_addr_d = s2_addr_calc;
            s2_byp_d  = (s2_addr_calc == 6'd0);
        end
        if (eo) begin
            ko_d     = ko_q + 6'd1;
            do_idx_d = ko_q;
        end

        // A clear drops everything in flight, including a sample arriving in the same cycle.
        if (clear) begin
            dl_d      = '0;
            k1_d      = '0;
            k2_d      = '0;
            ko_d      = '0;
            s1_addr_d = '0;
            s1_byp_d  = 1'b0;
            s2_addr_d = '0;
            s2_byp_d  = 1'b0;
            do_en_d   = 1'b0;
            do_idx_d  = '0;
            do_last_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dl_q      <= '0;
            k1_q      <= '0;
            k2_q      <= '0;
            ko_q      <= '0;
            s1_addr_q <= '0;
            s1_byp_q  <= 1'b0;
            s2_addr_q <= '0;
            s2_byp_q  <= 1'b0;
            do_en_q   <= 1'b0;
            do_idx_q  <= '0;
            do_last_q <= 1'b0;
        end else begin
            dl_q      <= dl_d;
            k1_q      <= k1_d;
            k2_q      <= k2_d;
            ko_q      <= ko_d;
            s1_addr_q <= s1_addr_d;
            s1_byp_q  <= s1_byp_d;
            s2_addr_q <= s2_addr_d;
            s2_byp_q  <= s2_byp_d;
            do_en_q   <= do_en_d;
            do_idx_q  <= do_idx_d;
            do_last_q <= do_last_d;
        end
    end

    assign s1_tw_addr = s1_addr_q;
    assign s1_tw_byp  = s1_byp_q;
    assign s2_tw_addr = s2_addr_q;
    assign s2_tw_byp  = s2_byp_q;
    assign do_en      = do_en_q;
    assign do_idx     = do_idx_q;
    assign do_last    = do_last_q;
    assign busy       = |dl_q;

endmodule
